// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU register map and stream-master state encoding
package npu_pkg;

    // Register offsets from the NPU base address, shared with the NPU block
    localparam logic [31:0] TypeAddr   = 32'h0;
    localparam logic [31:0] InputAddr  = 32'h4;
    localparam logic [31:0] OutputAddr = 32'h8;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        WR_IN,
        RD_REQ,
        RD_CAP,
        RESP
    } npu_ms_state_e;

endpackage

// File: rtl/npu_stream_master.sv
// rtl/npu_stream_master.sv - stream-to-NPU register bus master, one element in flight
module npu_stream_master
    import npu_pkg::*;
#(
    parameter int                DWidth   = 32,
    parameter logic [DWidth-1:0] BaseAddr = '0,
    parameter int                CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                type_valid_i,
    output logic                type_ready_o,
    input  logic [DWidth-1:0]   type_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DWidth-1:0]   in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DWidth-1:0]   out_data_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] count_o,
    output logic                npu_cen_o,
    output logic                npu_wen_o,
    output logic [DWidth-1:0]   npu_addr_o,
    output logic [DWidth-1:0]   npu_wdata_o,
    input  logic [DWidth-1:0]   npu_rdata_i
);

    localparam logic [DWidth-1:0] TypeRegAddr   = BaseAddr + DWidth'(TypeAddr);
    localparam logic [DWidth-1:0] InputRegAddr  = BaseAddr + DWidth'(InputAddr);
    localparam logic [DWidth-1:0] OutputRegAddr = BaseAddr + DWidth'(OutputAddr);

    npu_ms_state_e       state_q, state_d;
    logic [DWidth-1:0]   type_q, type_d;
    logic [DWidth-1:0]   opnd_q, opnd_d;
    logic [DWidth-1:0]   result_q, result_d;
    logic [CntWidth-1:0] count_q, count_d;

    // Next-state and register updates; type requests win over operands in IDLE
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (type_valid_i) begin
                    type_d  = type_i;
                    state_d = CFG;
                end else if (in_valid_i) begin
                    opnd_d  = in_data_i;
                    state_d = WR_IN;
                end
            end
            CFG: begin
                count_d = '0;
                state_d = IDLE;
            end
            WR_IN:  state_d = RD_REQ;
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                // Read data arrives the cycle after the read request
                result_d = npu_rdata_i;
                state_d  = RESP;
            end
            RESP: begin
                if (out_ready_i) begin
                    count_d = count_q + CntWidth'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NPU bus cycle decode; bus is parked at zero whenever no cycle is active
    always_comb begin
        npu_cen_o   = 1'b0;
        npu_wen_o   = 1'b0;
        npu_addr_o  = '0;
        npu_wdata_o = '0;
        unique case (state_q)
            CFG: begin
                npu_cen_o   = 1'b1;
                npu_wen_o   = 1'b1;
                npu_addr_o  = TypeRegAddr;
                npu_wdata_o = type_q;
            end
            WR_IN: begin
                npu_cen_o   = 1'b1;
                npu_wen_o   = 1'b1;
                npu_addr_o  = InputRegAddr;
                npu_wdata_o = opnd_q;
            end
            RD_REQ: begin
                npu_cen_o  = 1'b1;
                npu_addr_o = OutputRegAddr;
            end
            default: begin
                npu_cen_o   = 1'b0;
                npu_wen_o   = 1'b0;
                npu_addr_o  = '0;
                npu_wdata_o = '0;
            end
        endcase
    end

    // Stream handshakes; readies are masked during reset so every output reads 0
    always_comb begin
        type_ready_o = (state_q == IDLE) && !rst_i;
        in_ready_o   = (state_q == IDLE) && !type_valid_i && !rst_i;
        out_valid_o  = (state_q == RESP);
        out_data_o   = result_q;
        busy_o       = (state_q != IDLE);
        count_o      = count_q;
    end

    // State and datapath registers; reset drops any element in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            type_q   <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_npu_stream_master.sv
// tb/tb_npu_stream_master.sv - directed self-checking bench for npu_stream_master
module tb_npu_stream_master;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          type_valid;
    logic          type_ready;
    logic [DW-1:0] type_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [CW-1:0] count;
    logic          npu_cen;
    logic          npu_wen;
    logic [DW-1:0] npu_addr;
    logic [DW-1:0] npu_wdata;
    logic [DW-1:0] npu_rdata = '0;
    logic [DW-1:0] npu_in_reg = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    npu_stream_master #(
        .DWidth   (DW),
        .BaseAddr (32'h0),
        .CntWidth (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .type_valid_i (type_valid),
        .type_ready_o (type_ready),
        .type_i       (type_in),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .busy_o       (busy),
        .count_o      (count),
        .npu_cen_o    (npu_cen),
        .npu_wen_o    (npu_wen),
        .npu_addr_o   (npu_addr),
        .npu_wdata_o  (npu_wdata),
        .npu_rdata_i  (npu_rdata)
    );

    // NPU model: ReLU on the Input register; read data is only meaningful the cycle after a read
    always @(posedge clk) begin
        if (npu_cen && npu_wen && npu_addr == 32'h4)
            npu_in_reg <= npu_wdata;
        if (npu_cen && !npu_wen && npu_addr == 32'h8)
            npu_rdata <= npu_in_reg[31] ? 32'h0 : npu_in_reg;
        else
            npu_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cycles, output int lat);
        lat = 0;
        while (!out_valid && lat < max_cycles) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        int sent;
        int got;
        int cyc;
        int last;
        logic acc;

        rst        = 1'b1;
        type_valid = 1'b0;
        type_in    = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        step();
        step();

        check_eq("rst_type_ready", 32'(type_ready), 32'h0);
        check_eq("rst_in_ready",   32'(in_ready),   32'h0);
        check_eq("rst_busy",       32'(busy),       32'h0);
        check_eq("rst_count",      32'(count),      32'h0);
        check_eq("rst_out_valid",  32'(out_valid),  32'h0);
        check_eq("rst_cen",        32'(npu_cen),    32'h0);
        rst = 1'b0;
        step();

        // Type write
        type_valid = 1'b1;
        type_in    = 32'h2;
        #1;
        check_eq("cfg_type_ready_c0", 32'(type_ready), 32'h1);
        check_eq("cfg_in_ready_c0",   32'(in_ready),   32'h0);
        step();
        type_valid = 1'b0;
        check_eq("cfg_cen",   32'(npu_cen), 32'h1);
        check_eq("cfg_wen",   32'(npu_wen), 32'h1);
        check_eq("cfg_addr",  npu_addr,     32'h0);
        check_eq("cfg_wdata", npu_wdata,    32'h2);
        check_eq("cfg_busy",  32'(busy),    32'h1);
        step();
        check_eq("cfg_type_ready_c2", 32'(type_ready), 32'h1);
        check_eq("cfg_busy_c2",       32'(busy),       32'h0);
        check_eq("cfg_count",         32'(count),      32'h0);

        // Single negative operand, ReLU gives 0
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFF6;
        out_ready = 1'b1;
        #1;
        check_eq("op_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check_eq("op_wr_cen",   32'(npu_cen), 32'h1);
        check_eq("op_wr_wen",   32'(npu_wen), 32'h1);
        check_eq("op_wr_addr",  npu_addr,     32'h4);
        check_eq("op_wr_wdata", npu_wdata,    32'hFFFF_FFF6);
        step();
        check_eq("op_rd_cen",  32'(npu_cen), 32'h1);
        check_eq("op_rd_wen",  32'(npu_wen), 32'h0);
        check_eq("op_rd_addr", npu_addr,     32'h8);
        step();
        check_eq("op_cap_cen",   32'(npu_cen),   32'h0);
        check_eq("op_cap_valid", 32'(out_valid), 32'h0);
        step();
        check_eq("op_out_valid", 32'(out_valid), 32'h1);
        check_eq("op_out_data",  out_data,       32'h0);
        step();
        check_eq("op_after_valid", 32'(out_valid), 32'h0);
        check_eq("op_count",       32'(count),     32'h1);

        // Backpressure for 10 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_valid",    32'(out_valid), 32'h1);
            check_eq("bp_data",     out_data,       32'h5);
            check_eq("bp_in_ready", 32'(in_ready),  32'h0);
            check_eq("bp_cen",      32'(npu_cen),   32'h0);
            step();
        end
        out_ready = 1'b1;
        step();
        check_eq("bp_after_valid", 32'(out_valid), 32'h0);
        check_eq("bp_count",       32'(count),     32'h2);

        // Simultaneous type and operand: type first, operand accepted in cycle 2
        type_valid = 1'b1;
        type_in    = 32'h3;
        in_valid   = 1'b1;
        in_data    = 32'h7;
        #1;
        check_eq("sim_in_ready_c0",   32'(in_ready),   32'h0);
        check_eq("sim_type_ready_c0", 32'(type_ready), 32'h1);
        step();
        type_valid = 1'b0;
        check_eq("sim_cfg_cen",   32'(npu_cen), 32'h1);
        check_eq("sim_cfg_wen",   32'(npu_wen), 32'h1);
        check_eq("sim_cfg_addr",  npu_addr,     32'h0);
        check_eq("sim_cfg_wdata", npu_wdata,    32'h3);
        step();
        check_eq("sim_in_ready_c2", 32'(in_ready), 32'h1);
        check_eq("sim_count_c2",    32'(count),    32'h0);
        step();
        in_valid = 1'b0;
        check_eq("sim_wr_addr",  npu_addr,  32'h4);
        check_eq("sim_wr_wdata", npu_wdata, 32'h7);
        wait_valid(10, lat);
        check_eq("sim_valid_cycle", 32'(lat + 3), 32'h6);
        check_eq("sim_out_data",    out_data,     32'h7);
        step();
        check_eq("sim_count", 32'(count), 32'h1);

        // Reset during RD_REQ
        in_valid = 1'b1;
        in_data  = 32'h9;
        step();
        in_valid = 1'b0;
        step();
        check_eq("rr_rd_cen", 32'(npu_cen), 32'h1);
        check_eq("rr_rd_wen", 32'(npu_wen), 32'h0);
        rst = 1'b1;
        #1;
        check_eq("rr_cen",        32'(npu_cen),    32'h0);
        check_eq("rr_addr",       npu_addr,        32'h0);
        check_eq("rr_busy",       32'(busy),       32'h0);
        check_eq("rr_type_ready", 32'(type_ready), 32'h0);
        check_eq("rr_in_ready",   32'(in_ready),   32'h0);
        check_eq("rr_count",      32'(count),      32'h0);
        check_eq("rr_out_valid",  32'(out_valid),  32'h0);
        check_eq("rr_out_data",   out_data,        32'h0);
        step();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen++;
        end
        check_eq("rr_no_valid",     32'(seen),  32'h0);
        check_eq("rr_count_after",  32'(count), 32'h0);

        // Counter wrap: 17 back-to-back elements with CntWidth = 4
        in_valid  = 1'b1;
        in_data   = 32'd100;
        out_ready = 1'b1;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        last      = 0;
        while (got < 17 && cyc < 300) begin
            if (out_valid) begin
                check_eq("wrap_data", out_data, 32'(100 + got));
                if (got > 0)
                    check_eq("wrap_gap", 32'(cyc - last), 32'h5);
                last = cyc;
                got++;
            end
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                sent++;
                if (sent == 17)
                    in_valid = 1'b0;
                else
                    in_data = 32'(100 + sent);
            end
        end
        check_eq("wrap_results", 32'(got),   32'd17);
        check_eq("wrap_count",   32'(count), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
